// File: rtl/spi_sensor_slave.sv
// SPI responder emulating an 8-bit serial light sensor: 16-bit frames of {4'b0, sample, 4'b0}, MSB first.
// Optional macro SPI_SENSOR_RAMP_EN: shadow sample increments on every completed frame (self-test ramp).
module spi_sensor_slave #(
  parameter int FRAME_W = 16,
  parameter int LEAD_Z  = 4,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              ss,
  output logic              miso,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              frame_done,
  output logic              frame_abort,
  output logic [7:0]        frame_cnt
);

  localparam int CNT_W = $clog2(FRAME_W + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic logic [FRAME_W-1:0] build_frame(input logic [DATA_W-1:0] d);
    logic [FRAME_W-1:0] f;
    f = '0;
    f[FRAME_W-1-LEAD_Z -: DATA_W] = d;
    return f;
  endfunction

  logic [1:0]         sclk_sync_r;
  logic               sclk_prev_r;
  logic [1:0]         ss_sync_r;
  logic               ss_prev_r;
  state_t             state_r;
  logic [FRAME_W-1:0] shift_r;
  logic [CNT_W-1:0]   bit_cnt_r;
  logic [DATA_W-1:0]  shadow_r;
  logic               miso_r;
  logic               sample_ready_r;
  logic               frame_done_r;
  logic               frame_abort_r;
  logic [7:0]         frame_cnt_r;

  logic               sclk_rise_s;
  logic               ss_fall_s;
  logic               ss_rise_s;
  logic               capture_s;

  // Two-flop synchronizers plus edge-detect history for the asynchronous SPI inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_r <= 2'b00;
      sclk_prev_r <= 1'b0;
      ss_sync_r   <= 2'b11;
      ss_prev_r   <= 1'b1;
    end else begin
      sclk_sync_r <= {sclk_sync_r[0], sclk};
      sclk_prev_r <= sclk_sync_r[1];
      ss_sync_r   <= {ss_sync_r[0], ss};
      ss_prev_r   <= ss_sync_r[1];
    end
  end

  assign sclk_rise_s = sclk_sync_r[1] & ~sclk_prev_r;
  assign ss_fall_s   = ~ss_sync_r[1] & ss_prev_r;
  assign ss_rise_s   = ss_sync_r[1] & ~ss_prev_r;
  assign capture_s   = sample_valid & sample_ready_r & (state_r == IDLE);

  // Frame sequencer: capture, load on ss fall, shift on sclk rise, close on ss rise
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      shift_r        <= '0;
      bit_cnt_r      <= '0;
      shadow_r       <= '0;
      miso_r         <= 1'b0;
      sample_ready_r <= 1'b1;
      frame_done_r   <= 1'b0;
      frame_abort_r  <= 1'b0;
      frame_cnt_r    <= 8'd0;
    end else begin
      frame_done_r  <= 1'b0;
      frame_abort_r <= 1'b0;
      case (state_r)
        IDLE: begin
          miso_r         <= 1'b0;
          sample_ready_r <= 1'b1;
          if (capture_s) begin
            shadow_r <= sample_data;
          end else begin
            shadow_r <= shadow_r;
          end
          // A same-cycle sclk rise only loads; it is not counted as a bit
          if (ss_fall_s) begin
            shift_r        <= build_frame(capture_s ? sample_data : shadow_r);
            bit_cnt_r      <= '0;
            sample_ready_r <= 1'b0;
            state_r        <= SHIFT;
          end else begin
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          sample_ready_r <= 1'b0;
          if (ss_rise_s) begin
            state_r        <= IDLE;
            miso_r         <= 1'b0;
            sample_ready_r <= 1'b1;
            if (bit_cnt_r == CNT_W'(FRAME_W)) begin
              frame_done_r <= 1'b1;
              frame_cnt_r  <= frame_cnt_r + 8'd1;
`ifdef SPI_SENSOR_RAMP_EN
              shadow_r     <= shadow_r + DATA_W'(1);
`else
              shadow_r     <= shadow_r;
`endif
            end else begin
              frame_abort_r <= 1'b1;
            end
          end else if (sclk_rise_s) begin
            if (bit_cnt_r < CNT_W'(FRAME_W)) begin
              miso_r    <= shift_r[FRAME_W-1];
              shift_r   <= {shift_r[FRAME_W-2:0], 1'b0};
              bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            end else begin
              miso_r <= 1'b0;
            end
          end else begin
            miso_r <= miso_r;
          end
        end
        default: begin
          state_r        <= IDLE;
          miso_r         <= 1'b0;
          sample_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign miso         = miso_r;
  assign sample_ready = sample_ready_r;
  assign frame_done   = frame_done_r;
  assign frame_abort  = frame_abort_r;
  assign frame_cnt    = frame_cnt_r;

endmodule
